wb_inject_arbiter: RTL
======================

# wb_inject_arbiter

Per-node writeback arbiter and buffer between a cell's force pipelines and that node's cell-to-destination-ID mapping slot. It takes writeback requests from `NUM_REQ` force pipelines and grants them round-robin. Granted words go into a small FIFO, and the FIFO presents one writeback word per cycle to the mapping/ring-injection path under a valid/ready handshake. It also tracks end-of-phase, asserting `wb_done` once every pipeline has finished and all its writebacks have left the node.

## Interface
- `NUM_REQ`, 4, number of force pipelines sharing this node's injection port
- `DATA_WIDTH`, 32, force component width
- `CELL_ID_WIDTH`, 3, per-axis cell ID width
- `PARTICLE_ID_WIDTH`, 7, particle ID width
- `ID_WIDTH`, 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH, neighbor particle ID width
- `WB_WIDTH`, ID_WIDTH+3*DATA_WIDTH, writeback word width
- `FIFO_DEPTH`, 4, buffer entries; power of two, at least 2
- `CNT_WIDTH`, 16, writeback counter width

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `phase_start`  in  1  one-cycle pulse that begins a force-evaluation phase
- `req_valid`  in  NUM_REQ  per-pipeline writeback valid
- `req_data`  in  NUM_REQ×WB_WIDTH  per-pipeline writeback word
- `req_last`  in  NUM_REQ  qualifies `req_valid`; marks the pipeline's final writeback of the phase
- `req_ready`  out  NUM_REQ  grant; the word is accepted when `req_valid` and `req_ready` are both high
- `wb_valid`  out  1  buffered word available
- `wb_data`  out  WB_WIDTH  FIFO head, feeding the destination-ID mapping slot
- `wb_ready`  in  1  ring injection accepts
- `wb_count`  out  CNT_WIDTH  words injected this phase
- `wb_done`  out  1  phase complete, held until the next `phase_start`

## Operation
- States: IDLE, RUN, DRAIN, DONE. The state resets to IDLE.
- IDLE:
  - `req_ready` is all zero.
  - `phase_start` moves to RUN, clears `wb_count`, the per-requester `last_seen` flags and the round-robin pointer.
- RUN:
  - Arbitration is round-robin over `req_valid`, starting at pointer `rr` (0..NUM_REQ-1).
  - At most one grant per cycle. A grant is issued only when FIFO count < FIFO_DEPTH.
  - The full check uses the registered count. A pop in the same cycle does not free a slot for a push.
  - After a grant to requester g, `rr` becomes (g+1) mod NUM_REQ. With no grant, `rr` holds.
  - A grant while `req_last[g]` is high sets `last_seen[g]`.
  - When all `last_seen` bits are set (including bits set this cycle), the next state is DRAIN.
- DRAIN:
  - `req_ready` is all zero.
  - When the FIFO count reaches 0, the next state is DONE.
- DONE:
  - `wb_done` is 1.
  - `phase_start` moves to RUN with the same clears as from IDLE.
- `phase_start` in RUN or DRAIN is ignored.
- FIFO:
  - A push and a pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - `wb_valid` is (count != 0). `wb_data` is the head entry, stable while `wb_valid` is high and `wb_ready` is low.
- `wb_count` increments on each `wb_valid` && `wb_ready` and saturates at all-ones.
- Reset during any state returns to IDLE immediately:
  - FIFO emptied.
  - `wb_count` = 0.
  - Buffered data discarded.

## Timing
- Reset values:
  - `req_ready` = 0
  - `wb_valid` = 0
  - `wb_data` = 0
  - `wb_count` = 0
  - `wb_done` = 0
- `req_ready` is combinational from `req_valid`, the state, `rr` and the registered count. It never depends on `wb_ready`.
- Latency: a word accepted at edge N gives `wb_valid` high after edge N, so the head appears 1 cycle after acceptance when the FIFO was empty.
- Sustained throughput is 1 word/cycle while `wb_ready` stays high.
- `wb_done` rises the cycle after the FIFO empties in DRAIN. It falls the cycle after `phase_start`.

## Structure
- Shared package `md_wb_pkg` holds:
  - the width parameters as localparams
  - the `wb_word_t` typedef (ID, then force x/y/z from MSB to LSB)
  - the state enum `wb_arb_state_e`
- Sub-module `wb_fifo`: a synchronous FIFO with push/pop/count/head and asynchronous active-low reset.
- The arbiter, the phase FSM and the counter stay in `wb_inject_arbiter`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN with 3 words buffered -> next cycle `wb_valid`=0, `wb_count`=0, state IDLE, `req_ready`=0.
- **Round-robin fairness:** NUM_REQ=4, all requesters valid continuously, `wb_ready`=1 -> grants in order 0,1,2,3,0,1… and `wb_data` order matches; 1 word out per cycle after the first.
- **Backpressure/full:** `wb_ready`=0, all requesters valid -> exactly 4 grants, then `req_ready`=0. Raise `wb_ready` for 1 cycle -> one pop and no push that cycle; the next cycle grants one.
- **Single requester:** only requester 2 valid for 5 words -> grants to 2 on consecutive cycles, `rr` returns to 3 after each, `wb_count`=5.
- **Phase completion:** each requester sends 2 words, the second with `req_last`, with `wb_ready` toggling -> DRAIN after the 8th grant, `wb_done`=1 one cycle after the FIFO empties, `wb_count`=8.
- **Restart:** `phase_start` in DONE -> `wb_done` falls next cycle, `wb_count`=0. `phase_start` issued during DRAIN has no effect.

Source files
------------

// File: rtl/md_wb_pkg.sv
// md_wb_pkg: shared widths, writeback word layout and arbiter state type
package md_wb_pkg;
    localparam int NUM_REQ = 4;
    localparam int DATA_WIDTH = 32;
    localparam int CELL_ID_WIDTH = 3;
    localparam int PARTICLE_ID_WIDTH = 7;
    localparam int ID_WIDTH = 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH;
    localparam int WB_WIDTH = ID_WIDTH+3*DATA_WIDTH;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_WIDTH = 16;
    localparam int RR_WIDTH = $clog2(NUM_REQ);
    localparam int FCNT_WIDTH = $clog2(FIFO_DEPTH)+1;
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [DATA_WIDTH-1:0] fx;
        logic [DATA_WIDTH-1:0] fy;
        logic [DATA_WIDTH-1:0] fz;
    } wb_word_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wb_arb_state_e;
    function automatic logic [RR_WIDTH-1:0] rr_inc(input logic [RR_WIDTH-1:0] g);
        return (g == RR_WIDTH'(NUM_REQ-1)) ? '0 : g + 1'b1;
    endfunction
endpackage

// File: rtl/wb_inject_arbiter_if.sv
// wb_inject_arbiter_if: pipeline writeback requests and the injection-side handshake
interface wb_inject_arbiter_if;
    import md_wb_pkg::*;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_last;
    logic [NUM_REQ-1:0] req_ready;
    wb_word_t [NUM_REQ-1:0] req_data;
    logic wb_valid;
    logic wb_ready;
    wb_word_t wb_data;
    modport slave (
        input req_valid, req_last, req_data, wb_ready,
        output req_ready, wb_valid, wb_data
    );
    modport master (
        output req_valid, req_last, req_data, wb_ready,
        input req_ready, wb_valid, wb_data
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous writeback buffer with occupancy count and head output
module wb_fifo
    import md_wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input logic clk,
    input logic rst_n,
    input logic push,
    input wb_word_t din,
    input logic pop,
    output wb_word_t head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW+1;
    wb_word_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/wb_inject_arbiter.sv
// wb_inject_arbiter: round-robin writeback arbiter, injection buffer and end-of-phase tracking
module wb_inject_arbiter
    import md_wb_pkg::*;
(
    input logic clk,
    input logic rst_n,
    input logic phase_start,
    wb_inject_arbiter_if.slave bus,
    output logic [CNT_WIDTH-1:0] wb_count,
    output logic wb_done
);
    wb_arb_state_e state, state_nxt;
    logic [RR_WIDTH-1:0] rr, gnt_idx, idx;
    logic [NUM_REQ-1:0] gnt, last_seen, last_nxt;
    logic [FCNT_WIDTH-1:0] fcount;
    logic start, pop;
    // Full check uses the registered count, so a same-cycle pop never frees a slot
    always_comb begin
        gnt = '0;
        gnt_idx = rr;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = RR_WIDTH'((int'(rr) + i) % NUM_REQ);
            if (state == RUN && fcount < FCNT_WIDTH'(FIFO_DEPTH) && bus.req_valid[idx] && gnt == '0) begin
                gnt[idx] = 1'b1;
                gnt_idx = idx;
            end
        end
    end
    assign last_nxt = last_seen | (gnt & bus.req_last);
    always_comb begin
        state_nxt = state;
        start = 1'b0;
        case (state)
            IDLE, DONE: if (phase_start) begin
                state_nxt = RUN;
                start = 1'b1;
            end
            RUN: if (&last_nxt) state_nxt = DRAIN;
            DRAIN: if (fcount == '0) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= '0;
            last_seen <= '0;
            wb_count <= '0;
        end else if (start) begin
            rr <= '0;
            last_seen <= '0;
            wb_count <= '0;
        end else begin
            if (|gnt) begin
                rr <= rr_inc(gnt_idx);
                last_seen <= last_nxt;
            end
            if (pop && !(&wb_count)) wb_count <= wb_count + 1'b1;
        end
    end
    assign pop = bus.wb_valid && bus.wb_ready;
    assign bus.req_ready = gnt;
    assign bus.wb_valid = fcount != '0;
    assign wb_done = state == DONE;
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(|gnt),
        .din(bus.req_data[gnt_idx]),
        .pop(pop),
        .head(bus.wb_data),
        .count(fcount)
    );
endmodule
